// File: rtl/interrupt_ack_sequencer_if.sv
// CPU-side bundle of the 8259A-style interrupt acknowledge sequencer.
// The slave modport is the sequencer; the master modport is the resolver/CPU/command side.
interface interrupt_ack_sequencer_if;
  logic [7:0] interrupt;
  logic       inta_n;
  logic [4:0] vector_base;
  logic       auto_eoi;
  logic       eoi_nonspecific;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       eoi_rotate;
  logic       int_out;
  logic [7:0] in_service_register;
  logic [7:0] highest_level_in_service;
  logic [7:0] clear_irr;
  logic [7:0] data_out;
  logic       data_oe;

  modport slave (
    input  interrupt, inta_n, vector_base, auto_eoi,
    input  eoi_nonspecific, eoi_specific, eoi_level, eoi_rotate,
    output int_out, in_service_register, highest_level_in_service,
    output clear_irr, data_out, data_oe
  );

  modport master (
    output interrupt, inta_n, vector_base, auto_eoi,
    output eoi_nonspecific, eoi_specific, eoi_level, eoi_rotate,
    input  int_out, in_service_register, highest_level_in_service,
    input  clear_irr, data_out, data_oe
  );
endinterface

// File: rtl/interrupt_ack_sequencer.sv
// 8086-mode INTA sequencer with ISR bookkeeping and EOI handling for an 8259A-style controller.
// Optional feature macro: SPECIFIC_EOI_EN enables the specific EOI command (eoi_specific/eoi_level).
module interrupt_ack_sequencer #(
  parameter int NUM_LEVELS = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  interrupt_ack_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PEND  = 3'd1,
    S_ACK1  = 3'd2,
    S_WAIT2 = 3'd3,
    S_ACK2  = 3'd4
  } state_t;

  function automatic logic [2:0] f_encode(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
      else      idx = idx;
    end
    return idx;
  endfunction

  function automatic logic [7:0] f_onehot(input logic [2:0] lvl);
    return 8'h01 << lvl;
  endfunction

  state_t     r_state;
  state_t     w_next_state;
  logic       r_inta_prev;
  logic       r_int_out;
  logic [7:0] r_isr;
  logic [7:0] r_hlis;
  logic [7:0] r_clear_irr;
  logic [7:0] r_data_out;
  logic       r_data_oe;
  logic [2:0] r_level;
  logic       r_spurious;

  logic       w_inta_fall;
  logic       w_first_fall;
  logic       w_spurious;
  logic [2:0] w_ack_level;
  logic [7:0] w_set_mask;
  logic [7:0] w_aeoi_mask;
  logic [7:0] w_eoi_mask;
  logic [7:0] w_isr_next;
  logic       w_ns_found;
  logic [2:0] w_ns_level;
  logic       w_eoi_hit;
  logic [2:0] w_eoi_level;

  assign w_inta_fall  = r_inta_prev & ~bus.inta_n;
  assign w_first_fall = (r_state == S_PEND) & w_inta_fall;
  assign w_spurious   = (bus.interrupt == 8'h00);
  assign w_ack_level  = w_spurious ? 3'd7 : f_encode(bus.interrupt);
  assign w_set_mask   = (w_first_fall && !w_spurious) ? f_onehot(w_ack_level) : 8'h00;
  assign w_aeoi_mask  = ((r_state == S_ACK2) && bus.inta_n && bus.auto_eoi && !r_spurious)
                        ? f_onehot(r_level) : 8'h00;
  assign w_eoi_mask   = w_eoi_hit ? f_onehot(w_eoi_level) : 8'h00;
  // A bit being set by the acknowledge overrides any clear of the same bit.
  assign w_isr_next   = (r_isr & ~(w_eoi_mask | w_aeoi_mask)) | w_set_mask;

  // Handshake next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.interrupt != 8'h00) w_next_state = S_PEND;
        else                        w_next_state = S_IDLE;
      end
      S_PEND: begin
        if (w_inta_fall)                 w_next_state = S_ACK1;
        else if (bus.interrupt == 8'h00) w_next_state = S_IDLE;
        else                             w_next_state = S_PEND;
      end
      S_ACK1: begin
        if (bus.inta_n) w_next_state = S_WAIT2;
        else            w_next_state = S_ACK1;
      end
      S_WAIT2: begin
        if (w_inta_fall) w_next_state = S_ACK2;
        else             w_next_state = S_WAIT2;
      end
      S_ACK2: begin
        if (bus.inta_n) w_next_state = S_IDLE;
        else            w_next_state = S_ACK2;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Non-specific EOI target: first in-service level after the rotation base, wrapping.
  always_comb begin : ns_search
    logic [2:0] cand;
    w_ns_found = 1'b0;
    w_ns_level = 3'd0;
    cand       = 3'd0;
    for (int i = 1; i <= NUM_LEVELS; i++) begin
      cand = f_encode(r_hlis) + 3'(i);
      if (!w_ns_found && r_isr[cand]) begin
        w_ns_found = 1'b1;
        w_ns_level = cand;
      end else begin
        w_ns_found = w_ns_found;
      end
    end
  end

`ifdef SPECIFIC_EOI_EN
  // EOI command select; specific outranks non-specific.
  always_comb begin
    w_eoi_hit   = 1'b0;
    w_eoi_level = 3'd0;
    if (bus.eoi_specific) begin
      w_eoi_hit   = r_isr[bus.eoi_level];
      w_eoi_level = bus.eoi_level;
    end else if (bus.eoi_nonspecific) begin
      w_eoi_hit   = w_ns_found;
      w_eoi_level = w_ns_level;
    end else begin
      w_eoi_hit   = 1'b0;
    end
  end
`else
  logic w_unused_specific;
  assign w_unused_specific = bus.eoi_specific ^ (^bus.eoi_level);

  // EOI command select; only non-specific EOI exists in this build.
  always_comb begin
    w_eoi_hit   = 1'b0;
    w_eoi_level = 3'd0;
    if (bus.eoi_nonspecific) begin
      w_eoi_hit   = w_ns_found;
      w_eoi_level = w_ns_level;
    end else begin
      w_eoi_hit   = 1'b0;
    end
  end
`endif

  // State, ISR, rotation base and registered CPU-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_inta_prev <= 1'b1;
      r_int_out   <= 1'b0;
      r_isr       <= 8'h00;
      r_hlis      <= 8'h80;
      r_clear_irr <= 8'h00;
      r_data_out  <= 8'h00;
      r_data_oe   <= 1'b0;
      r_level     <= 3'd7;
      r_spurious  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_inta_prev <= bus.inta_n;
      r_int_out   <= (w_next_state == S_PEND);
      r_isr       <= w_isr_next;
      r_clear_irr <= w_set_mask;
      r_data_oe   <= (w_next_state == S_ACK2);
      r_data_out  <= (w_next_state == S_ACK2) ? {bus.vector_base, r_level} : 8'h00;
      if (w_first_fall) begin
        r_level    <= w_ack_level;
        r_spurious <= w_spurious;
      end else begin
        r_level    <= r_level;
        r_spurious <= r_spurious;
      end
      if (w_eoi_hit && bus.eoi_rotate) r_hlis <= f_onehot(w_eoi_level);
      else                             r_hlis <= r_hlis;
    end
  end

  assign bus.int_out                  = r_int_out;
  assign bus.in_service_register      = r_isr;
  assign bus.highest_level_in_service = r_hlis;
  assign bus.clear_irr                = r_clear_irr;
  assign bus.data_out                 = r_data_out;
  assign bus.data_oe                  = r_data_oe;

endmodule
